// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/response bus between the MEM stage and data memory.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word loads/stores over a req/gnt/rvalid bus, front-end stall,
// branch resolution and the registered MEM/WB outputs.
//
// state | meaning
// IDLE  | no access in flight; non-memory ops pass straight to MEM/WB
// REQ   | dmem_req held with stable addr/wdata/we until grant or timeout
// RSP   | load granted, waiting for rvalid or timeout
// DONE  | access finished; MEM/WB written from held controls, stall released
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      flush_in,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic                      branch_in,
  input  logic                      zero_ctrl_in,
  input  logic                      mem_to_reg_in,
  input  logic                      reg_write_in,
  input  logic [31:0]               alu_result_in,
  input  logic [31:0]               alu_in_2_in,
  input  logic [4:0]                reg_rd_in,
  mem_access_stage_if.master        dmem,
  output logic                      stall_out,
  output logic                      pc_src_out,
  output logic                      mem_err_out,
  output logic                      mem_to_reg_out,
  output logic                      reg_write_out,
  output logic [4:0]                reg_rd_out,
  output logic [31:0]               alu_result_out,
  output logic [31:0]               mem_rdata_out
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic        op;
  logic        tmo_hit;
  logic        err_q;
  logic        mem_to_reg_q;
  logic        reg_write_q;
  logic [4:0]  rd_q;
  logic [31:0] alu_q;
  logic [31:0] rdata_q;

  assign op         = mem_read_in | mem_write_in;
  // >= rather than == so a grant on the last REQ cycle still leaves RSP one cycle
  assign tmo_hit    = (tmo_cnt >= TMO_LAST);
  assign pc_src_out = branch_in & zero_ctrl_in;
  assign stall_out  = (state == REQ) || (state == RSP) || ((state == IDLE) && op);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state            <= IDLE;
      tmo_cnt          <= '0;
      err_q            <= 1'b0;
      mem_to_reg_q     <= 1'b0;
      reg_write_q      <= 1'b0;
      rd_q             <= '0;
      alu_q            <= '0;
      rdata_q          <= '0;
      dmem.dmem_req    <= 1'b0;
      dmem.dmem_we     <= 1'b0;
      dmem.dmem_addr   <= '0;
      dmem.dmem_wdata  <= '0;
      mem_err_out      <= 1'b0;
      mem_to_reg_out   <= 1'b0;
      reg_write_out    <= 1'b0;
      reg_rd_out       <= '0;
      alu_result_out   <= '0;
      mem_rdata_out    <= '0;
    end else begin
      // MEM/WB carries a bubble unless an instruction retires on this edge
      mem_err_out    <= 1'b0;
      mem_to_reg_out <= 1'b0;
      reg_write_out  <= 1'b0;
      reg_rd_out     <= '0;
      alu_result_out <= '0;
      mem_rdata_out  <= '0;

      case (state)
        IDLE: begin
          if (!op) begin
            if (!flush_in) begin
              mem_to_reg_out <= mem_to_reg_in;
              reg_write_out  <= reg_write_in;
              reg_rd_out     <= reg_rd_in;
              alu_result_out <= alu_result_in;
            end
          end else begin
            mem_to_reg_q <= mem_to_reg_in;
            reg_write_q  <= reg_write_in;
            rd_q         <= reg_rd_in;
            alu_q        <= alu_result_in;
            tmo_cnt      <= '0;
            if (alu_result_in[1:0] != 2'b00) begin
              err_q   <= 1'b1;
              rdata_q <= ERR_RDATA;
              state   <= DONE;
            end else begin
              err_q           <= 1'b0;
              rdata_q         <= '0;
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= mem_write_in & ~mem_read_in;
              dmem.dmem_addr  <= alu_result_in;
              dmem.dmem_wdata <= alu_in_2_in;
              state           <= REQ;
            end
          end
        end

        REQ: begin
          if (dmem.dmem_gnt) begin
            dmem.dmem_req <= 1'b0;
            tmo_cnt       <= tmo_cnt + 8'd1;
            state         <= dmem.dmem_we ? DONE : RSP;
          end else if (tmo_hit) begin
            dmem.dmem_req <= 1'b0;
            err_q         <= 1'b1;
            rdata_q       <= ERR_RDATA;
            state         <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        RSP: begin
          if (dmem.dmem_rvalid) begin
            rdata_q <= dmem.dmem_rdata;
            state   <= DONE;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            rdata_q <= ERR_RDATA;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        DONE: begin
          if (!flush_in) begin
            mem_to_reg_out <= mem_to_reg_q;
            reg_write_out  <= reg_write_q & ~err_q;
            reg_rd_out     <= rd_q;
            alu_result_out <= alu_q;
            mem_rdata_out  <= rdata_q;
          end
          mem_err_out <= err_q;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
